// File: rtl/scope_capture_if.sv
// Sample-stream, buffer-write and frame-handshake bundle for the scope capture controller.
interface scope_capture_if #(
    parameter int unsigned DW     = 12,
    parameter int unsigned ADDR_W = 10
);
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DW-1:0]     buf_wdata;
    logic [ADDR_W-1:0] trig_addr;
    logic              frame_ready;
    logic              frame_ack;
    logic              auto_trig;

    // Controller side: consumes samples and acks, produces writes and frame status.
    modport master (
        input  s_valid, s_data, frame_ack,
        output buf_we, buf_addr, buf_wdata, trig_addr, frame_ready, auto_trig
    );

    // Environment side: ADC source plus display consumer.
    modport slave (
        output s_valid, s_data, frame_ack,
        input  buf_we, buf_addr, buf_wdata, trig_addr, frame_ready, auto_trig
    );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope acquisition sequencer: decimation, circular pre-trigger capture,
// edge/auto triggering and frame hand-off to the display side.
module scope_capture_ctrl #(
    parameter int unsigned DEPTH   = 640,
    parameter int unsigned PRETRIG = 320,
    parameter int unsigned DW      = 12,
    parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        run_mode,
    input  logic              arm,
    input  logic [DW-1:0]     trig_level,
    input  logic              trig_rising,
    input  logic [15:0]       decim,
    input  logic [23:0]       auto_timeout,
    scope_capture_if.master   bus,
    output logic              busy,
    output logic [2:0]        state
);

    localparam int unsigned POST_N = DEPTH - PRETRIG;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [15:0]       dcnt_q, dcnt_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic [23:0]       tcnt_q, tcnt_d;
    logic [DW-1:0]     prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic [DW-1:0]     cfg_level_q, cfg_level_d;
    logic              cfg_rising_q, cfg_rising_d;
    logic [15:0]       cfg_decim_q, cfg_decim_d;
    logic [23:0]       cfg_timeout_q, cfg_timeout_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DW-1:0]     buf_wdata_q, buf_wdata_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              ready_q, ready_d;
    logic              auto_q, auto_d;
    logic              busy_q, busy_d;

    logic              active, stop, accept, enter_pre;
    logic              edge_hit, timeout_hit;
    logic [ADDR_W-1:0] wptr_inc;
    logic [CNT_W-1:0]  scnt_inc;
    logic [23:0]       tcnt_inc;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        dcnt_d        = dcnt_q;
        scnt_d        = scnt_q;
        tcnt_d        = tcnt_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        cfg_level_d   = cfg_level_q;
        cfg_rising_d  = cfg_rising_q;
        cfg_decim_d   = cfg_decim_q;
        cfg_timeout_d = cfg_timeout_q;
        buf_we_d      = 1'b0;
        buf_addr_d    = buf_addr_q;
        buf_wdata_d   = buf_wdata_q;
        trig_addr_d   = trig_addr_q;
        ready_d       = ready_q;
        auto_d        = auto_q;
        enter_pre     = 1'b0;

        active   = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
        stop     = (run_mode == 2'd0);
        accept   = active && bus.s_valid && (dcnt_q == 16'd0);
        wptr_inc = (wptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wptr_q + ADDR_W'(1);
        scnt_inc = scnt_q + CNT_W'(1);
        tcnt_inc = tcnt_q + 24'd1;

        if (cfg_rising_q) begin
            edge_hit = prev_valid_q && (prev_q < cfg_level_q) && (bus.s_data >= cfg_level_q);
        end else begin
            edge_hit = prev_valid_q && (prev_q >= cfg_level_q) && (bus.s_data < cfg_level_q);
        end
        timeout_hit = (run_mode == 2'd2) && (tcnt_inc >= cfg_timeout_q);

        if (active && bus.s_valid) begin
            dcnt_d = (dcnt_q == 16'd0) ? cfg_decim_q : dcnt_q - 16'd1;
        end

        if (accept && !stop) begin
            buf_we_d    = 1'b1;
            buf_addr_d  = wptr_q;
            buf_wdata_d = bus.s_data;
            wptr_d      = wptr_inc;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm && !stop) begin
                    enter_pre = 1'b1;
                end
            end
            ST_PRE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    prev_d       = bus.s_data;
                    prev_valid_d = 1'b1;
                    scnt_d       = scnt_inc;
                    if (scnt_inc == CNT_W'(PRETRIG)) begin
                        state_d = ST_WAIT_TRIG;
                        tcnt_d  = '0;
                    end
                end
            end
            ST_WAIT_TRIG: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    prev_d       = bus.s_data;
                    prev_valid_d = 1'b1;
                    tcnt_d       = tcnt_inc;
                    if (edge_hit || timeout_hit) begin
                        trig_addr_d = wptr_q;
                        auto_d      = !edge_hit;
                        scnt_d      = CNT_W'(1);
                        if (POST_N == 1) begin
                            state_d = ST_DONE;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    scnt_d = scnt_inc;
                    if (scnt_inc == CNT_W'(POST_N)) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.frame_ack) begin
                    ready_d = 1'b0;
                    if ((run_mode == 2'd1) || (run_mode == 2'd2)) begin
                        enter_pre = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame start: snapshot configuration and restart per-frame counters.
        if (enter_pre) begin
            cfg_level_d   = trig_level;
            cfg_rising_d  = trig_rising;
            cfg_decim_d   = decim;
            cfg_timeout_d = auto_timeout;
            dcnt_d        = '0;
            scnt_d        = '0;
            tcnt_d        = '0;
            prev_valid_d  = 1'b0;
            state_d       = (PRETRIG == 0) ? ST_WAIT_TRIG : ST_PRE;
        end

        busy_d = (state_d == ST_PRE) || (state_d == ST_WAIT_TRIG) || (state_d == ST_POST);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wptr_q        <= '0;
            dcnt_q        <= '0;
            scnt_q        <= '0;
            tcnt_q        <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            cfg_level_q   <= '0;
            cfg_rising_q  <= 1'b0;
            cfg_decim_q   <= '0;
            cfg_timeout_q <= '0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_wdata_q   <= '0;
            trig_addr_q   <= '0;
            ready_q       <= 1'b0;
            auto_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            dcnt_q        <= dcnt_d;
            scnt_q        <= scnt_d;
            tcnt_q        <= tcnt_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            cfg_level_q   <= cfg_level_d;
            cfg_rising_q  <= cfg_rising_d;
            cfg_decim_q   <= cfg_decim_d;
            cfg_timeout_q <= cfg_timeout_d;
            buf_we_q      <= buf_we_d;
            buf_addr_q    <= buf_addr_d;
            buf_wdata_q   <= buf_wdata_d;
            trig_addr_q   <= trig_addr_d;
            ready_q       <= ready_d;
            auto_q        <= auto_d;
            busy_q        <= busy_d;
        end
    end

    // Output drive.
    assign bus.buf_we      = buf_we_q;
    assign bus.buf_addr    = buf_addr_q;
    assign bus.buf_wdata   = buf_wdata_q;
    assign bus.trig_addr   = trig_addr_q;
    assign bus.frame_ready = ready_q;
    assign bus.auto_trig   = auto_q;
    assign busy            = busy_q;
    assign state           = state_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl with DEPTH=16, PRETRIG=4.
module tb_scope_capture_ctrl;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned PRETRIG = 4;
    localparam int unsigned DW      = 12;
    localparam int unsigned AW      = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  run_mode;
    logic        arm;
    logic [11:0] trig_level;
    logic        trig_rising;
    logic [15:0] decim;
    logic [23:0] auto_timeout;
    logic        busy;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;
    int we_count;

    scope_capture_if #(.DW(DW), .ADDR_W(AW)) bus ();

    scope_capture_ctrl #(.DEPTH(DEPTH), .PRETRIG(PRETRIG), .DW(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .run_mode     (run_mode),
        .arm          (arm),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .decim        (decim),
        .auto_timeout (auto_timeout),
        .bus          (bus),
        .busy         (busy),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        arm;
        logic        vld;
        logic [11:0] data;
        logic        ack;
        logic        exp_we;
        logic [3:0]  exp_addr;
        logic [11:0] exp_wdata;
        logic [2:0]  exp_state;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [11:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic ramp(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            feed(12'(1900 + 20 * k));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run_mode = 2'd0; arm = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.frame_ack = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic configure(input logic [1:0] m, input logic [11:0] lvl, input logic rise,
                             input logic [15:0] dc, input logic [23:0] to);
        run_mode = m; trig_level = lvl; trig_rising = rise; decim = dc; auto_timeout = to;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(bus.buf_we), 0);
        check({tag, "_addr"},  32'(bus.buf_addr), 0);
        check({tag, "_wdata"}, 32'(bus.buf_wdata), 0);
        check({tag, "_taddr"}, 32'(bus.trig_addr), 0);
        check({tag, "_ready"}, 32'(bus.frame_ready), 0);
        check({tag, "_auto"},  32'(bus.auto_trig), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_state"}, 32'(state), 0);
    endtask

    initial begin
        trig_level = '0; trig_rising = 1'b0; decim = '0; auto_timeout = '0;
        do_reset();
        reset = 1'b1;
        step();
        check_all_zero("reset");
        reset = 1'b0;

        // Rising ramp frame, decim 0: trigger on 2060 (sample 8), DONE after sample 19.
        vecs[0] = '{2'd1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 4'd0, 12'd0, 3'd1, 1'b0};
        for (int k = 0; k < 20; k++) begin
            vecs[k + 1] = '{2'd1, 1'b0, 1'b1, 12'(1900 + 20 * k), 1'b0,
                            1'b1, 4'(k), 12'(1900 + 20 * k),
                            (k < 3) ? 3'd1 : (k < 8) ? 3'd2 : (k < 19) ? 3'd3 : 3'd4,
                            (k == 19) ? 1'b1 : 1'b0};
        end
        vecs[21] = '{2'd1, 1'b0, 1'b1, 12'd3000, 1'b0, 1'b0, 4'd0, 12'd0, 3'd4, 1'b1};
        vecs[22] = '{2'd1, 1'b0, 1'b1, 12'd3000, 1'b0, 1'b0, 4'd0, 12'd0, 3'd4, 1'b1};
        vecs[23] = '{2'd1, 1'b0, 1'b0, 12'd0,    1'b1, 1'b0, 4'd0, 12'd0, 3'd1, 1'b0};

        configure(2'd1, 12'd2048, 1'b1, 16'd0, 24'd0);
        we_count = 0;
        for (int i = 0; i < 24; i++) begin
            run_mode      = vecs[i].mode;
            arm           = vecs[i].arm;
            bus.s_valid   = vecs[i].vld;
            bus.s_data    = vecs[i].data;
            bus.frame_ack = vecs[i].ack;
            step();
            if (bus.buf_we) we_count++;
            check($sformatf("vec%0d_we", i), 32'(bus.buf_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_addr", i),  32'(bus.buf_addr),  32'(vecs[i].exp_addr));
                check($sformatf("vec%0d_wdata", i), 32'(bus.buf_wdata), 32'(vecs[i].exp_wdata));
            end
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_ready", i), 32'(bus.frame_ready), 32'(vecs[i].exp_ready));
            if (i == 22) begin
                check("ramp_trig_addr", 32'(bus.trig_addr), 8);
                check("ramp_auto", 32'(bus.auto_trig), 0);
                check("ramp_busy_done", 32'(busy), 0);
            end
        end
        arm = 1'b0; bus.frame_ack = 1'b0; bus.s_valid = 1'b0;
        check("ramp_we_count", 32'(we_count), 20);
        check("ramp_rearm_busy", 32'(busy), 1);

        // decim=2, valid every cycle: one write per 3 samples, wrap inside the frame.
        do_reset();
        configure(2'd1, 12'd2048, 1'b1, 16'd2, 24'd0);
        arm_pulse();
        for (int j = 0; j < 64; j++) begin
            feed((j < 30) ? 12'd100 : 12'd3000);
            check($sformatf("dec_we%0d", j), 32'(bus.buf_we), (j % 3 == 0) ? 1 : 0);
            if (j % 3 == 0) check($sformatf("dec_addr%0d", j), 32'(bus.buf_addr), (j / 3) % 16);
        end
        check("dec_state", 32'(state), 4);
        check("dec_taddr", 32'(bus.trig_addr), 10);
        check("dec_ready", 32'(bus.frame_ready), 1);

        // Auto mode: constant input forces trigger on 5th WAIT_TRIG sample.
        do_reset();
        configure(2'd2, 12'd2048, 1'b1, 16'd0, 24'd5);
        arm_pulse();
        for (int k = 0; k < 8; k++) feed(12'd100);
        check("auto_wait", 32'(state), 2);
        feed(12'd100);
        check("auto_post", 32'(state), 3);
        check("auto_taddr", 32'(bus.trig_addr), 8);
        check("auto_flag", 32'(bus.auto_trig), 1);
        for (int k = 9; k < 20; k++) feed(12'd100);
        check("auto_done", 32'(state), 4);
        check("auto_ready", 32'(bus.frame_ready), 1);

        // Auto mode with a real edge on the timeout sample: edge wins.
        do_reset();
        configure(2'd2, 12'd2048, 1'b1, 16'd0, 24'd5);
        arm_pulse();
        for (int k = 0; k < 8; k++) feed(12'd100);
        feed(12'd3000);
        check("prio_state", 32'(state), 3);
        check("prio_taddr", 32'(bus.trig_addr), 8);
        check("prio_auto", 32'(bus.auto_trig), 0);

        // Normal mode never triggers on a flat input.
        do_reset();
        configure(2'd1, 12'd2048, 1'b1, 16'd0, 24'd5);
        arm_pulse();
        for (int k = 0; k < 40; k++) feed(12'd100);
        check("norm_wait", 32'(state), 2);
        check("norm_ready", 32'(bus.frame_ready), 0);

        // Falling edge 1100 -> 999.
        do_reset();
        configure(2'd1, 12'd1000, 1'b0, 16'd0, 24'd0);
        arm_pulse();
        for (int k = 0; k < 4; k++) feed(12'd1500);
        feed(12'd1200); feed(12'd1100);
        check("fall_wait", 32'(state), 2);
        feed(12'd999);
        check("fall_post", 32'(state), 3);
        check("fall_taddr", 32'(bus.trig_addr), 6);

        // Falling boundary: 1001 -> 1000 is not below level; 1000 -> 999 is.
        do_reset();
        configure(2'd1, 12'd1000, 1'b0, 16'd0, 24'd0);
        arm_pulse();
        for (int k = 0; k < 4; k++) feed(12'd1500);
        feed(12'd1001); feed(12'd1000); feed(12'd1000);
        check("fallb_wait", 32'(state), 2);
        feed(12'd999);
        check("fallb_post", 32'(state), 3);
        check("fallb_taddr", 32'(bus.trig_addr), 7);

        // Single mode: arm during POST ignored, ack returns to IDLE, no writes until arm.
        do_reset();
        configure(2'd3, 12'd2048, 1'b1, 16'd0, 24'd0);
        arm_pulse();
        ramp(0, 9);
        arm = 1'b1;
        feed(12'(1900 + 200));
        arm = 1'b0;
        check("single_arm_post", 32'(state), 3);
        ramp(11, 19);
        check("single_done", 32'(state), 4);
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
        check("single_idle", 32'(state), 0);
        check("single_ready_drop", 32'(bus.frame_ready), 0);
        we_count = 0;
        for (int k = 0; k < 5; k++) begin
            feed(12'd2500);
            if (bus.buf_we) we_count++;
        end
        check("single_nowrite", 32'(we_count), 0);
        arm_pulse();
        check("single_rearm", 32'(state), 1);

        // Stop mid-POST with a simultaneous sample: no write, IDLE next cycle.
        do_reset();
        configure(2'd1, 12'd2048, 1'b1, 16'd0, 24'd0);
        arm_pulse();
        ramp(0, 9);
        check("stop_pre_state", 32'(state), 3);
        run_mode = 2'd0;
        feed(12'(1900 + 200));
        check("stop_we", 32'(bus.buf_we), 0);
        check("stop_state", 32'(state), 0);
        check("stop_busy", 32'(busy), 0);
        check("stop_taddr_hold", 32'(bus.trig_addr), 8);

        // Reset while in WAIT_TRIG clears every output.
        run_mode = 2'd1;
        arm_pulse();
        for (int k = 0; k < 6; k++) feed(12'd100);
        check("rst_pre_state", 32'(state), 2);
        check("rst_pre_wdata", 32'(bus.buf_wdata), 100);
        reset = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 12'd100;
        step();
        bus.s_valid = 1'b0;
        check_all_zero("rstwait");
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
